// File: rtl/cpu_types_pkg.sv
// Shared types for the memory subsystem: RAM handshake status, the machine
// word, and the arbiter's FSM state encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arbstate_t;

  // Width of an index into n channels; a single channel still gets one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: returns the first requesting channel
// at or after ptr, wrapping from CH-1 back to 0.
module rr_picker
  import cpu_types_pkg::*;
#(
  parameter int CH = 4,
  parameter int IW = idx_width(CH)
) (
  input  logic [CH-1:0] req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          valid
);

  // Scan offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    int j;
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    for (int i = CH - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % CH;
      if (req[j]) begin
        valid = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one RAM port between the icache and dcache
// channels of CPUS cores. Channel 2k is dcache k, channel 2k+1 is icache k.
// One cycle of arbitration in IDLE, then the granted channel drives the RAM
// combinationally until the RAM reports ACCESS or the channel withdraws.
//
//   state | meaning
//   IDLE  | no transaction; pick next requester at/after ptr into gnt
//   GRANT | channel gnt owns the RAM; complete on ACCESS, abort on drop
module ram_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS = 2,
  parameter int AW   = 32,
  parameter int DW   = 32
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic [CPUS-1:0]           iREN,
  input  logic [CPUS-1:0][AW-1:0]   iaddr,
  output logic [CPUS-1:0]           iwait,
  output logic [CPUS-1:0][DW-1:0]   iload,
  input  logic [CPUS-1:0]           dREN,
  input  logic [CPUS-1:0]           dWEN,
  input  logic [CPUS-1:0][AW-1:0]   daddr,
  input  logic [CPUS-1:0][DW-1:0]   dstore,
  output logic [CPUS-1:0]           dwait,
  output logic [CPUS-1:0][DW-1:0]   dload,
  output logic [AW-1:0]             ramaddr,
  output logic                      ramREN,
  output logic                      ramWEN,
  output logic [DW-1:0]             ramstore,
  input  logic [DW-1:0]             ramload,
  input  ramstate_t                 ramstate
);

  localparam int CH = 2 * CPUS;
  localparam int IW = idx_width(CH);

  arbstate_t           state;
  logic [IW-1:0]       gnt;
  logic [IW-1:0]       ptr;
  logic [IW-1:0]       pick_idx;
  logic                pick_valid;
  logic [IW-1:0]       ptr_next;
  logic                done;

  logic [CH-1:0]           ch_req;
  logic [CH-1:0]           ch_ren;
  logic [CH-1:0]           ch_wen;
  logic [CH-1:0][AW-1:0]   ch_addr;
  logic [CH-1:0][DW-1:0]   ch_store;

  // Flatten per-core ports into the channel view; a dcache write beats a read.
  for (genvar k = 0; k < CPUS; k++) begin : g_chan
    assign ch_req[2*k]     = dREN[k] | dWEN[k];
    assign ch_wen[2*k]     = dWEN[k];
    assign ch_ren[2*k]     = dREN[k] & ~dWEN[k];
    assign ch_addr[2*k]    = daddr[k];
    assign ch_store[2*k]   = dstore[k];

    assign ch_req[2*k+1]   = iREN[k];
    assign ch_wen[2*k+1]   = 1'b0;
    assign ch_ren[2*k+1]   = iREN[k];
    assign ch_addr[2*k+1]  = iaddr[k];
    assign ch_store[2*k+1] = '0;

    assign dwait[k] = ~(done && (gnt == IW'(2*k)));
    assign iwait[k] = ~(done && (gnt == IW'(2*k+1)));
    assign dload[k] = ramload;
    assign iload[k] = ramload;
  end

  rr_picker #(.CH(CH), .IW(IW)) u_picker (
    .req   (ch_req),
    .ptr   (ptr),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign ptr_next = (gnt == IW'(CH - 1)) ? '0 : gnt + IW'(1);

  // Arbitration FSM: grant, complete, or abandon when the owner withdraws.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      gnt   <= '0;
      ptr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            gnt   <= pick_idx;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (!ch_req[gnt]) begin
            state <= IDLE;
          end else if (ramstate == ACCESS) begin
            ptr   <= ptr_next;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM side is a pass-through of the granted channel; quiet otherwise.
  always_comb begin
    ramaddr  = '0;
    ramstore = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    done     = 1'b0;
    if (state == GRANT) begin
      ramaddr  = ch_addr[gnt];
      ramstore = ch_store[gnt];
      if (ch_req[gnt]) begin
        ramREN = ch_ren[gnt];
        ramWEN = ch_wen[gnt];
        done   = (ramstate == ACCESS);
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter (CPUS=2, four channels). Expected
// completions are queued by each scenario; a negedge monitor pops and checks
// them whenever a wait line goes low.
module tb_ram_arbiter;
  import cpu_types_pkg::*;

  localparam int CPUS = 2;
  localparam int AW   = 32;
  localparam int DW   = 32;

  logic                    CLK = 1'b0;
  logic                    nRST = 1'b0;
  logic [CPUS-1:0]         iREN, dREN, dWEN, iwait, dwait;
  logic [CPUS-1:0][AW-1:0] iaddr, daddr;
  logic [CPUS-1:0][DW-1:0] dstore, iload, dload;
  logic [AW-1:0]           ramaddr;
  logic                    ramREN, ramWEN;
  logic [DW-1:0]           ramstore, ramload;
  ramstate_t               ramstate;

  typedef struct {
    int            ch;
    logic [AW-1:0] addr;
    logic          wen;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   comp_cyc[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   m_lows, m_ch;
  exp_t m_e;
  logic [DW-1:0] m_lane;

  ram_arbiter #(.CPUS(CPUS), .AW(AW), .DW(DW)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramaddr(ramaddr), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
  );

  initial forever #5 CLK = ~CLK;
  initial forever begin @(posedge CLK); cyc = cyc + 1; end

  // Completion monitor: at most one wait low; each low wait must match the
  // oldest queued expectation.
  initial forever begin
    @(negedge CLK);
    if (nRST) begin
      m_lows = $countones(~{iwait, dwait});
      total++;
      if (m_lows > 1) begin
        bad++;
        $display("FAIL one_hot_wait got=%0d low waits exp<=1 (iwait=%b dwait=%b)", m_lows, iwait, dwait);
      end
      if (m_lows == 1) begin
        m_ch = 0;
        for (int k = 0; k < CPUS; k++) begin
          if (!dwait[k]) m_ch = 2*k;
          if (!iwait[k]) m_ch = 2*k + 1;
        end
        done_cnt++;
        comp_cyc.push_back(cyc);
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_completion got ch=%0d exp=none", m_ch);
        end else begin
          m_e = sb.pop_front();
          if (m_ch !== m_e.ch) begin
            bad++;
            $display("FAIL grant_channel got=%0d exp=%0d", m_ch, m_e.ch);
          end
          total++;
          if (ramaddr !== m_e.addr) begin
            bad++;
            $display("FAIL comp_addr got=%0h exp=%0h", ramaddr, m_e.addr);
          end
          total++;
          if (ramWEN !== m_e.wen || ramREN !== !m_e.wen) begin
            bad++;
            $display("FAIL comp_enables got wen=%b ren=%b exp wen=%b", ramWEN, ramREN, m_e.wen);
          end
          total++;
          m_lane = (m_ch % 2 == 0) ? dload[m_ch/2] : iload[m_ch/2];
          if (m_e.wen) begin
            if (ramstore !== m_e.data) begin
              bad++;
              $display("FAIL comp_store got=%0h exp=%0h", ramstore, m_e.data);
            end
          end else if (m_lane !== ramload) begin
            bad++;
            $display("FAIL comp_load got=%0h exp=%0h", m_lane, ramload);
          end
        end
      end
    end
  end

  task automatic clear_inputs();
    iREN = '0; dREN = '0; dWEN = '0;
    iaddr = '0; daddr = '0; dstore = '0;
    ramstate = FREE;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    clear_inputs();
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    ramload = 32'hCAFE_F00D;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    total++;
    if ({iwait, dwait} !== 4'hF) begin
      bad++; $display("FAIL reset_waits got=%b exp=1111", {iwait, dwait});
    end
    total++;
    if (ramREN !== 1'b0 || ramWEN !== 1'b0) begin
      bad++; $display("FAIL reset_enables got ren=%b wen=%b exp 0 0", ramREN, ramWEN);
    end
    total++;
    if (ramaddr !== '0 || ramstore !== '0) begin
      bad++; $display("FAIL reset_bus got addr=%0h store=%0h exp 0 0", ramaddr, ramstore);
    end
    total++;
    if (dut.ptr !== 2'd0 || dut.gnt !== 2'd0 || dut.state !== IDLE) begin
      bad++; $display("FAIL reset_regs got ptr=%0d gnt=%0d st=%0d exp 0 0 0", dut.ptr, dut.gnt, dut.state);
    end
    @(posedge CLK);
    #1 nRST = 1'b1;
  endtask

  task automatic test_single_read();
    int base;
    @(posedge CLK);
    #1 ramstate = FREE; daddr[0] = 32'h100; dREN[0] = 1'b1;
    @(negedge CLK);
    total++;
    if (ramREN !== 1'b0) begin
      bad++; $display("FAIL arb_latency got ren=%b exp=0", ramREN);
    end
    @(posedge CLK); #1;
    @(negedge CLK);
    total++;
    if (ramaddr !== 32'h100 || ramREN !== 1'b1 || ramWEN !== 1'b0) begin
      bad++; $display("FAIL read_drive got addr=%0h ren=%b wen=%b exp 100 1 0", ramaddr, ramREN, ramWEN);
    end
    total++;
    if (dwait[0] !== 1'b1) begin
      bad++; $display("FAIL read_wait_free got=%b exp=1", dwait[0]);
    end
    @(posedge CLK);
    #1 ramstate = ACCESS;
    sb.push_back('{ch: 0, addr: 32'h100, wen: 1'b0, data: '0});
    base = done_cnt;
    @(negedge CLK);
    total++;
    if (dwait[0] !== 1'b0) begin
      bad++; $display("FAIL read_wait_access got=%b exp=0", dwait[0]);
    end
    @(posedge CLK);
    #1 dREN[0] = 1'b0; ramstate = FREE;
    total++;
    if (done_cnt !== base + 1) begin
      bad++; $display("FAIL read_one_cycle got=%0d completions exp=1", done_cnt - base);
    end
    @(negedge CLK);
    total++;
    if (dut.ptr !== 2'd1 || dut.state !== IDLE) begin
      bad++; $display("FAIL read_ptr got ptr=%0d st=%0d exp 1 IDLE", dut.ptr, dut.state);
    end
  endtask

  task automatic test_write();
    @(posedge CLK);
    #1 dREN[1] = 1'b1; dWEN[1] = 1'b1; daddr[1] = 32'h200; dstore[1] = 32'hDEAD_BEEF;
    ramstate = ACCESS;
    sb.push_back('{ch: 2, addr: 32'h200, wen: 1'b1, data: 32'hDEAD_BEEF});
    @(negedge CLK);
    total++;
    if (ramWEN !== 1'b0) begin
      bad++; $display("FAIL write_latency got wen=%b exp=0", ramWEN);
    end
    @(posedge CLK); #1;
    @(negedge CLK);
    total++;
    if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramstore !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL write_drive got wen=%b ren=%b store=%0h exp 1 0 deadbeef", ramWEN, ramREN, ramstore);
    end
    total++;
    if (dwait[1] !== 1'b0) begin
      bad++; $display("FAIL write_wait got=%b exp=0", dwait[1]);
    end
    @(posedge CLK);
    #1 dREN[1] = 1'b0; dWEN[1] = 1'b0; ramstate = FREE;
    @(negedge CLK);
    total++;
    if (dut.ptr !== 2'd3) begin
      bad++; $display("FAIL write_ptr got=%0d exp=3", dut.ptr);
    end
  endtask

  task automatic test_round_robin();
    int base;
    bit hit;
    do_reset();
    @(posedge CLK);
    #1 dREN = 2'b11; iREN = 2'b11;
    daddr[0] = 32'h1000; iaddr[0] = 32'h1100; daddr[1] = 32'h1200; iaddr[1] = 32'h1300;
    ramstate = ACCESS;
    sb.push_back('{ch: 0, addr: 32'h1000, wen: 1'b0, data: '0});
    sb.push_back('{ch: 1, addr: 32'h1100, wen: 1'b0, data: '0});
    sb.push_back('{ch: 2, addr: 32'h1200, wen: 1'b0, data: '0});
    sb.push_back('{ch: 3, addr: 32'h1300, wen: 1'b0, data: '0});
    sb.push_back('{ch: 0, addr: 32'h1000, wen: 1'b0, data: '0});
    base = done_cnt;
    comp_cyc.delete();
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      @(posedge CLK); #1;
      if (done_cnt - base >= 5) hit = 1'b1;
    end
    dREN = '0; iREN = '0; ramstate = FREE;
    total++;
    if (!hit) begin
      bad++; $display("FAIL rr_timeout got=%0d completions exp=5", done_cnt - base);
    end
    for (int i = 1; i < comp_cyc.size() && i < 5; i++) begin
      total++;
      if (comp_cyc[i] - comp_cyc[i-1] !== 2) begin
        bad++; $display("FAIL rr_spacing got=%0d cycles exp=2 (idx %0d)", comp_cyc[i] - comp_cyc[i-1], i);
      end
    end
  endtask

  task automatic test_drop();
    int base;
    @(posedge CLK);
    #1 iREN[1] = 1'b1; iaddr[1] = 32'h300; ramstate = BUSY;
    base = done_cnt;
    @(posedge CLK); #1;
    @(negedge CLK);
    total++;
    if (dut.gnt !== 2'd3 || ramREN !== 1'b1 || iwait[1] !== 1'b1) begin
      bad++; $display("FAIL drop_grant got gnt=%0d ren=%b iwait=%b exp 3 1 1", dut.gnt, ramREN, iwait[1]);
    end
    @(posedge CLK);
    #1 iREN[1] = 1'b0;
    @(negedge CLK);
    total++;
    if (ramREN !== 1'b0 || ramWEN !== 1'b0 || iwait[1] !== 1'b1) begin
      bad++; $display("FAIL drop_quiet got ren=%b wen=%b iwait=%b exp 0 0 1", ramREN, ramWEN, iwait[1]);
    end
    @(posedge CLK); #1;
    @(negedge CLK);
    total++;
    if (dut.state !== IDLE || dut.ptr !== 2'd1 || done_cnt !== base) begin
      bad++; $display("FAIL drop_after got st=%0d ptr=%0d comps=%0d exp IDLE 1 0", dut.state, dut.ptr, done_cnt - base);
    end
    ramstate = FREE;
  endtask

  task automatic test_reset_mid();
    int base;
    bit hit;
    @(posedge CLK);
    #1 dREN[1] = 1'b1; daddr[1] = 32'h400; ramstate = BUSY;
    @(posedge CLK); #1;
    @(negedge CLK);
    total++;
    if (dut.gnt !== 2'd2 || ramREN !== 1'b1) begin
      bad++; $display("FAIL midrst_grant got gnt=%0d ren=%b exp 2 1", dut.gnt, ramREN);
    end
    #2 nRST = 1'b0;
    #1;
    total++;
    if ({iwait, dwait} !== 4'hF || ramREN !== 1'b0 || ramWEN !== 1'b0) begin
      bad++; $display("FAIL midrst_outputs got waits=%b ren=%b wen=%b exp 1111 0 0", {iwait, dwait}, ramREN, ramWEN);
    end
    total++;
    if (dut.state !== IDLE || dut.ptr !== 2'd0) begin
      bad++; $display("FAIL midrst_regs got st=%0d ptr=%0d exp IDLE 0", dut.state, dut.ptr);
    end
    @(posedge CLK);
    #1 nRST = 1'b1; dREN[0] = 1'b1; daddr[0] = 32'h500; ramstate = ACCESS;
    sb.push_back('{ch: 0, addr: 32'h500, wen: 1'b0, data: '0});
    sb.push_back('{ch: 2, addr: 32'h400, wen: 1'b0, data: '0});
    base = done_cnt;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(posedge CLK); #1;
      if (done_cnt - base >= 2) hit = 1'b1;
    end
    dREN = '0; ramstate = FREE;
    total++;
    if (!hit) begin
      bad++; $display("FAIL midrst_timeout got=%0d completions exp=2", done_cnt - base);
    end
  endtask

  task automatic test_error();
    @(posedge CLK);
    #1 iREN[0] = 1'b1; iaddr[0] = 32'h600; ramstate = ERROR; ramload = 32'h1234_5678;
    @(posedge CLK); #1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      total++;
      if (iwait[0] !== 1'b1 || dut.gnt !== 2'd1 || dut.state !== GRANT) begin
        bad++; $display("FAIL error_hold got iwait=%b gnt=%0d st=%0d exp 1 1 GRANT (cycle %0d)", iwait[0], dut.gnt, dut.state, i);
      end
      @(posedge CLK); #1;
    end
    ramstate = ACCESS;
    sb.push_back('{ch: 1, addr: 32'h600, wen: 1'b0, data: '0});
    @(negedge CLK);
    total++;
    if (iwait[0] !== 1'b0 || iload[0] !== 32'h1234_5678) begin
      bad++; $display("FAIL error_recover got iwait=%b iload=%0h exp 0 12345678", iwait[0], iload[0]);
    end
    @(posedge CLK);
    #1 iREN[0] = 1'b0; ramstate = FREE;
    @(negedge CLK);
    total++;
    if (dut.ptr !== 2'd2) begin
      bad++; $display("FAIL error_ptr got=%0d exp=2", dut.ptr);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_round_robin();
    test_drop();
    test_reset_mid();
    test_error();
    repeat (3) @(posedge CLK);
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL leftover_expectations got=%0d exp=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter CPUS, default 2, number of cores; each core has one icache and one dcache channel.
REQ-002 Parameter AW, default 32, address width.
REQ-003 Parameter DW, default 32, data width.
REQ-004 Derived constant CH = 2*CPUS:
  - channel 2k = dcache of core k.
  - channel 2k+1 = icache of core k.
REQ-005 Port list (name, direction, width, meaning):
  - CLK  in  1  single clock, rising edge.
  - nRST  in  1  asynchronous active-low reset.
  - iREN  in  CPUS  icache read request per core.
  - iaddr  in  CPUS x AW  icache address.
  - iwait  out  CPUS  icache stall, low for exactly one completion cycle.
  - iload  out  CPUS x DW  icache read data.
  - dREN  in  CPUS  dcache read request.
  - dWEN  in  CPUS  dcache write request.
  - daddr  in  CPUS x AW  dcache address.
  - dstore  in  CPUS x DW  dcache write data.
  - dwait  out  CPUS  dcache stall.
  - dload  out  CPUS x DW  dcache read data.
  - ramaddr  out  AW  RAM address.
  - ramREN  out  1  RAM read enable.
  - ramWEN  out  1  RAM write enable.
  - ramstore  out  DW  RAM write data.
  - ramload  in  DW  RAM read data.
  - ramstate  in  ramstate_t  RAM status: FREE, BUSY, ACCESS, ERROR.

Function
REQ-006 Channel request:
  - dcache: dREN|dWEN.
  - icache: iREN.
  - When dWEN and dREN are both high, the channel is a write (ramWEN=1, ramREN=0).
REQ-007 FSM states IDLE and GRANT; the granted channel index gnt and round-robin pointer ptr are registered.
REQ-008 IDLE with no request: stay IDLE; ramREN=ramWEN=0; ramaddr=0; ramstore=0.
REQ-009 IDLE with any request:
  - Select the first requesting channel at or after ptr, wrapping CH-1 to 0.
  - Register it as gnt and go to GRANT.
  - RAM outputs stay idle in this cycle (one-cycle arbitration latency).
REQ-010 GRANT: ramaddr, ramREN, ramWEN and ramstore are driven combinationally from channel gnt's current inputs.
REQ-011 GRANT with ramstate==ACCESS:
  - Drive the granted channel's wait low for that cycle only.
  - Set ptr to (gnt+1) mod CH.
  - Return to IDLE.
REQ-012 GRANT with ramstate FREE, BUSY or ERROR: hold all waits high and remain in GRANT.
REQ-013 GRANT when the granted channel drops its request:
  - Return to IDLE next cycle with ptr unchanged.
  - Drive ramREN=ramWEN=0 in that cycle.
  - Assert no completion.
REQ-014 Every non-granted wait is high in every cycle; at most one wait is low in any cycle.
REQ-015 ramload is broadcast to all iload and dload lanes; data is valid only where the corresponding wait is low.
REQ-016 A request arriving while another channel is granted waits; under continuous requests from all channels, no channel waits more than CH transactions.
REQ-017 When a request rises in the same cycle that the granted channel completes: the FSM goes to IDLE and arbitrates next cycle, giving a minimum 2-cycle turnaround between transactions.

Reset
REQ-018 On nRST low, asynchronously: state=IDLE, gnt=0, ptr=0.
REQ-019 Outputs during reset: all iwait/dwait=1, ramREN=ramWEN=0, ramaddr=0, ramstore=0.
REQ-020 Reset asserted mid-GRANT abandons the transaction; there is no completion and no ptr update.

Structure
REQ-021 In cpu_types_pkg:
  - ramstate_t and word_t (existing).
  - New enum arbstate_t {IDLE, GRANT}.
REQ-022 Sub-module rr_picker(CH): combinational round-robin select.
  - Inputs: req[CH], ptr.
  - Outputs: idx, valid.
REQ-023 Index widths are $clog2(CH), with a minimum of 1.

Verification
REQ-024 CPUS=2; dREN[0]=1 only, daddr[0]=0x100, ramstate ACCESS on the 2nd GRANT cycle -> ramaddr=0x100, ramREN=1; dwait[0] low one cycle; ptr=1.
REQ-025 All four channels request continuously, ramstate always ACCESS -> grant order 0,1,2,3,0; each completion 2 cycles apart.
REQ-026 dWEN[1]=dREN[1]=1, dstore[1]=0xDEADBEEF -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF.
REQ-027 Granted iREN[1] drops while ramstate=BUSY -> IDLE next cycle, no wait low, ptr unchanged.
REQ-028 nRST pulsed low during GRANT -> immediately all waits=1, ramREN=ramWEN=0; after release, the first grant starts from channel 0.
REQ-029 ramstate held ERROR for 10 cycles while granted -> wait stays high and gnt is stable; ACCESS afterwards completes normally.
